// File: rtl/sha3_axis_pkg.sv
// Shared types and helpers for the SHA-3 AXI-Stream block-input and digest-output paths.
package sha3_axis_pkg;

  typedef logic [63:0] lane_t;
  typedef lane_t [0:4][0:4] state_t;

  // Encoding matches the TUSER sideband on the digest stream
  typedef enum logic [1:0] {
    SHA224 = 2'd0,
    SHA256 = 2'd1,
    SHA384 = 2'd2,
    SHA512 = 2'd3
  } sha_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  // Widest digest; only this many low bits of the flattened state are ever kept
  localparam int unsigned CAPTURE_BITS = 512;

  function automatic int unsigned digest_bits(sha_mode_e mode);
    case (mode)
      SHA224:  return 224;
      SHA256:  return 256;
      SHA384:  return 384;
      default: return 512;
    endcase
  endfunction

  function automatic int unsigned num_beats(sha_mode_e mode, int dw);
    return (digest_bits(mode) + int'(dw) - 1) / int'(dw);
  endfunction

endpackage

// File: rtl/keccak_axis_tx_if.sv
// AXI4-Stream digest channel: word index on TDEST, captured SHA mode on TUSER.
interface keccak_axis_tx_if #(
  parameter int DATA_WIDTH = 16
) ();

  logic                  TVALID;
  logic                  TREADY;
  logic [DATA_WIDTH-1:0] TDATA;
  logic                  TLAST;
  logic [1:0]            TUSER;
  logic [7:0]            TDEST;

  modport master (
    output TVALID,
    output TDATA,
    output TLAST,
    output TUSER,
    output TDEST,
    input  TREADY
  );

  modport slave (
    input  TVALID,
    input  TDATA,
    input  TLAST,
    input  TUSER,
    input  TDEST,
    output TREADY
  );

endinterface

// File: rtl/keccak_axis_tx.sv
// Captures the Keccak state on DONE, truncates it to the selected digest length
// and streams it out as DATA_WIDTH beats over AXI4-Stream.
module keccak_axis_tx
  import sha3_axis_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  state_t                  D_in,
  input  logic                    DONE,
  input  logic [1:0]              SHA_MODE,
  keccak_axis_tx_if.master        m_axis,
  output logic                    BUSY,
  output logic                    OVERRUN
);

  tx_state_e                 state_q;
  tx_state_e                 state_d;
  logic [CAPTURE_BITS-1:0]   digest_q;
  sha_mode_e                 mode_q;
  logic [5:0]                idx_q;

  logic [CAPTURE_BITS-1:0]   flat_lo;
  logic [CAPTURE_BITS-1:0]   beat_shift;
  logic [5:0]                last_idx;
  logic                      is_last;
  logic                      hs;
  logic                      hs_last;
  logic                      capture;
  logic                      unused_state;

  // Lanes k = 0..7 (x + 5y) form the low 512 bits of the flattened state
  assign flat_lo = {D_in[2][1], D_in[1][1], D_in[0][1], D_in[4][0],
                    D_in[3][0], D_in[2][0], D_in[1][0], D_in[0][0]};

  // Lanes outside the capture window never reach the digest
  assign unused_state = ^D_in;

  // Keeps only the low digest_bits of the capture; zeroes the tail of a partial last beat
  function automatic logic [CAPTURE_BITS-1:0] digest_mask(sha_mode_e mode);
    logic [CAPTURE_BITS-1:0] m;
    m = '1;
    m = m >> (CAPTURE_BITS - digest_bits(mode));
    return m;
  endfunction

  assign last_idx = 6'(num_beats(mode_q, DATA_WIDTH) - 1);
  assign is_last  = (idx_q == last_idx);
  assign hs       = (state_q == SEND) && m_axis.TREADY;
  assign hs_last  = hs && is_last;
  // A new digest is accepted when idle, or back-to-back with the final handshake
  assign capture  = DONE && ((state_q == IDLE) || hs_last);

  assign beat_shift = digest_q >> (idx_q * DATA_WIDTH);

  // FSM state register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: stay in SEND when DONE coincides with the final handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (DONE) state_d = SEND;
      SEND:    if (hs_last && !DONE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: stream controls and beat payload derived from the registered index
  always_comb begin
    m_axis.TVALID = 1'b0;
    m_axis.TLAST  = 1'b0;
    m_axis.TDEST  = '0;
    m_axis.TDATA  = '0;
    m_axis.TUSER  = mode_q;
    BUSY          = 1'b0;
    if (state_q == SEND) begin
      m_axis.TVALID = 1'b1;
      m_axis.TLAST  = is_last;
      m_axis.TDEST  = {2'b00, idx_q};
      m_axis.TDATA  = beat_shift[DATA_WIDTH-1:0];
      BUSY          = 1'b1;
    end
  end

  // Digest capture and beat index; payload only moves on capture or handshake
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      digest_q <= '0;
      mode_q   <= SHA224;
      idx_q    <= '0;
    end else if (capture) begin
      digest_q <= flat_lo & digest_mask(sha_mode_e'(SHA_MODE));
      mode_q   <= sha_mode_e'(SHA_MODE);
      idx_q    <= '0;
    end else if (hs) begin
      idx_q    <= hs_last ? '0 : idx_q + 6'd1;
    end
  end

  // Sticky flag for a DONE that arrives while a packet is still in flight
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      OVERRUN <= 1'b0;
    end else if (DONE && (state_q == SEND) && !hs_last) begin
      OVERRUN <= 1'b1;
    end
  end

endmodule

// File: tb/tb_keccak_axis_tx.sv
// Bench for keccak_axis_tx: DW=16 and DW=64 instances share stimulus and are
// checked against a transaction-level digest model.
module tb_keccak_axis_tx;
  import sha3_axis_pkg::*;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  dest;
    logic        last;
    logic [1:0]  user;
  } beat_t;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        DONE = 1'b0;
  logic        tready = 1'b0;
  logic [1:0]  sha_mode = 2'd0;
  state_t      d_in = '0;

  logic        busy16, busy64, ovr16, ovr64;
  logic        o_valid [2];
  logic        o_last  [2];
  logic [63:0] o_data  [2];
  logic [7:0]  o_dest  [2];
  logic [1:0]  o_user  [2];
  logic        o_busy  [2];
  logic        o_ovr   [2];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  beat_t expq [2][$];
  logic  exp_ovr [2];

  keccak_axis_tx_if #(.DATA_WIDTH(16)) ax16 ();
  keccak_axis_tx_if #(.DATA_WIDTH(64)) ax64 ();

  assign ax16.TREADY = tready;
  assign ax64.TREADY = tready;

  keccak_axis_tx #(.DATA_WIDTH(16)) dut16 (
    .ACLK(ACLK), .ARESET(ARESET), .D_in(d_in), .DONE(DONE), .SHA_MODE(sha_mode),
    .m_axis(ax16), .BUSY(busy16), .OVERRUN(ovr16)
  );

  keccak_axis_tx #(.DATA_WIDTH(64)) dut64 (
    .ACLK(ACLK), .ARESET(ARESET), .D_in(d_in), .DONE(DONE), .SHA_MODE(sha_mode),
    .m_axis(ax64), .BUSY(busy64), .OVERRUN(ovr64)
  );

  assign o_valid[0] = ax16.TVALID;
  assign o_valid[1] = ax64.TVALID;
  assign o_last[0]  = ax16.TLAST;
  assign o_last[1]  = ax64.TLAST;
  assign o_data[0]  = {48'b0, ax16.TDATA};
  assign o_data[1]  = ax64.TDATA;
  assign o_dest[0]  = ax16.TDEST;
  assign o_dest[1]  = ax64.TDEST;
  assign o_user[0]  = ax16.TUSER;
  assign o_user[1]  = ax64.TUSER;
  assign o_busy[0]  = busy16;
  assign o_busy[1]  = busy64;
  assign o_ovr[0]   = ovr16;
  assign o_ovr[1]   = ovr64;

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int dw_of(int d);
    return (d == 0) ? 16 : 64;
  endfunction

  function automatic string tg(int d, string s);
    return $sformatf("dw%0d_%s", dw_of(d), s);
  endfunction

  function automatic int len_of(logic [1:0] m);
    case (m)
      2'd0:    return 224;
      2'd1:    return 256;
      2'd2:    return 384;
      default: return 512;
    endcase
  endfunction

  // Reference: walk digest bit positions directly through the lane numbering
  function automatic void push_packet(int d, state_t s, logic [1:0] m);
    int dw = dw_of(d);
    int len = len_of(m);
    int n = (len + dw - 1) / dw;
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.data = '0;
      for (int j = 0; j < dw; j++) begin
        int pos = i * dw + j;
        int k = pos / 64;
        if (pos < len) b.data[j] = s[k % 5][k / 5][pos % 64];
      end
      b.dest = 8'(i);
      b.last = (i == n - 1);
      b.user = m;
      expq[d].push_back(b);
    end
  endfunction

  // Check outputs mid-cycle, then advance the model across the coming edge
  task automatic cycle();
    logic hs, acc;
    @(negedge ACLK);
    for (int d = 0; d < 2; d++) begin
      chk(tg(d, "tvalid"), o_valid[d], expq[d].size() != 0);
      chk(tg(d, "busy"), o_busy[d], expq[d].size() != 0);
      chk(tg(d, "overrun"), o_ovr[d], exp_ovr[d]);
      if (expq[d].size() != 0) begin
        chk(tg(d, "tdata"), o_data[d], expq[d][0].data);
        chk(tg(d, "tdest"), o_dest[d], expq[d][0].dest);
        chk(tg(d, "tlast"), o_last[d], expq[d][0].last);
        chk(tg(d, "tuser"), o_user[d], expq[d][0].user);
      end
    end
    for (int d = 0; d < 2; d++) begin
      hs  = (expq[d].size() != 0) && tready;
      acc = DONE && ((expq[d].size() == 0) || (expq[d].size() == 1 && tready));
      if (DONE && !acc) exp_ovr[d] = 1'b1;
      if (hs) void'(expq[d].pop_front());
      if (acc) push_packet(d, d_in, sha_mode);
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk_reset(input string t);
    for (int d = 0; d < 2; d++) begin
      chk(tg(d, {t, "_tvalid"}), o_valid[d], 0);
      chk(tg(d, {t, "_tlast"}), o_last[d], 0);
      chk(tg(d, {t, "_tdata"}), o_data[d], 0);
      chk(tg(d, {t, "_tdest"}), o_dest[d], 0);
      chk(tg(d, {t, "_tuser"}), o_user[d], 0);
      chk(tg(d, {t, "_busy"}), o_busy[d], 0);
      chk(tg(d, {t, "_overrun"}), o_ovr[d], 0);
    end
  endtask

  task automatic start_packet(input logic [1:0] m);
    sha_mode = m;
    DONE = 1'b1;
    cycle();
    DONE = 1'b0;
  endtask

  task automatic run_until_dest(input int d, input int dest);
    int n = 0;
    while (!(expq[d].size() != 0 && expq[d][0].dest == 8'(dest)) && n < 200) begin
      cycle();
      n++;
    end
    if (n >= 200) chk(tg(d, "wait_dest_timeout"), 1, 0);
  endtask

  task automatic drain();
    int n = 0;
    tready = 1'b1;
    while ((expq[0].size() != 0 || expq[1].size() != 0) && n < 300) begin
      cycle();
      n++;
    end
    if (n >= 300) chk("drain_timeout", 1, 0);
    cycle();
  endtask

  task automatic randomize_state();
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        d_in[x][y] = {$urandom, $urandom};
  endtask

  initial begin
    int n;
    exp_ovr[0] = 1'b0;
    exp_ovr[1] = 1'b0;

    ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    chk_reset("rst");
    ARESET = 1'b0;
    cycle();

    // Mode 256 with known lanes; DW=64 sees the same state
    d_in = '0;
    d_in[0][0] = 64'h0123456789ABCDEF;
    d_in[1][0] = 64'hFEDCBA9876543210;
    d_in[3][0] = 64'hAAAABBBBCCCCDDDD;
    d_in[2][1] = 64'h1122334455667788;
    tready = 1'b1;
    start_packet(2'd1);
    chk("first_word16", o_data[0], 64'hCDEF);
    chk("first_valid16", o_valid[0], 1);

    // Backpressure held for three cycles at word 5
    run_until_dest(0, 5);
    tready = 1'b0;
    repeat (3) cycle();
    tready = 1'b1;
    cycle();
    chk("resume_dest16", o_dest[0], 6);
    drain();

    // Truncated partial last beat (DW=64, 224) and full 512
    start_packet(2'd0);
    drain();
    start_packet(2'd3);
    drain();

    // DONE coincident with the final handshake starts the next packet seamlessly
    start_packet(2'd1);
    n = 0;
    while (expq[0].size() != 1 && n < 200) begin
      cycle();
      n++;
    end
    if (n >= 200) chk("coinc_wait_timeout", 1, 0);
    randomize_state();
    start_packet(2'd2);
    chk("coinc_tvalid16", o_valid[0], 1);
    chk("coinc_tdest16", o_dest[0], 0);
    chk("coinc_tuser16", o_user[0], 2);
    chk("coinc_ovr16", o_ovr[0], 0);
    drain();

    // DONE in the middle of a 384-bit packet is dropped and flagged
    randomize_state();
    start_packet(2'd2);
    run_until_dest(0, 7);
    randomize_state();
    DONE = 1'b1;
    cycle();
    DONE = 1'b0;
    drain();
    chk("overrun_sticky16", o_ovr[0], 1);

    // Asynchronous reset mid-packet
    randomize_state();
    start_packet(2'd1);
    run_until_dest(0, 9);
    #2;
    ARESET = 1'b1;
    #1;
    chk_reset("arst");
    expq[0].delete();
    expq[1].delete();
    exp_ovr[0] = 1'b0;
    exp_ovr[1] = 1'b0;
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    randomize_state();
    start_packet(2'd3);
    chk("post_rst_dest16", o_dest[0], 0);
    drain();

    // Random traffic: sporadic DONE, random ready
    for (int i = 0; i < 600; i++) begin
      tready = ($urandom_range(0, 9) < 7);
      DONE = ($urandom_range(0, 14) == 0);
      if (DONE) begin
        randomize_state();
        sha_mode = 2'($urandom_range(0, 3));
      end
      cycle();
      DONE = 1'b0;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
